// File: rtl/pcie_rq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rq_arbiter
// Purpose  : Packet-granular round-robin sharing of the PCIe RQ port between
//            NUM_REQ requesters, with tag-based steering of RC completions.
//            Optional RQ_TAG_REMAP_EN overwrites the tag MSBs with the grant.
// Revision : 1.0  initial release
// ============================================================================
module pcie_rq_arbiter #(
    parameter int NUM_REQ             = 4,
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 62,
    parameter int AXI4_RC_TUSER_WIDTH = 75,
    parameter int SEL_BITS            = 2
) (
    input  logic                                   user_clk,
    input  logic                                   user_reset,
    input  logic                                   user_lnk_up,

    input  logic [NUM_REQ*C_DATA_WIDTH-1:0]        req_tdata,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0]          req_tkeep,
    input  logic [NUM_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
    input  logic [NUM_REQ-1:0]                     req_tlast,
    input  logic [NUM_REQ-1:0]                     req_tvalid,
    output logic [NUM_REQ-1:0]                     req_tready,

    output logic [C_DATA_WIDTH-1:0]                s_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]                  s_axis_rq_tkeep,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0]         s_axis_rq_tuser,
    output logic                                   s_axis_rq_tlast,
    output logic                                   s_axis_rq_tvalid,
    input  logic [3:0]                             s_axis_rq_tready,

    input  logic [C_DATA_WIDTH-1:0]                m_axis_rc_tdata,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0]         m_axis_rc_tuser,
    input  logic [KEEP_WIDTH-1:0]                  m_axis_rc_tkeep,
    input  logic                                   m_axis_rc_tlast,
    input  logic                                   m_axis_rc_tvalid,
    output logic                                   m_axis_rc_tready,

    output logic [C_DATA_WIDTH-1:0]                cpl_tdata,
    output logic [AXI4_RC_TUSER_WIDTH-1:0]         cpl_tuser,
    output logic [KEEP_WIDTH-1:0]                  cpl_tkeep,
    output logic                                   cpl_tlast,
    output logic [NUM_REQ-1:0]                     cpl_tvalid,
    input  logic [NUM_REQ-1:0]                     cpl_tready,

    output logic [NUM_REQ-1:0]                     grant,
    output logic                                   rc_drop
);

    localparam int                  c_rq_tag_msb = 103;
    localparam int                  c_rc_tag_msb = 71;
    localparam logic [SEL_BITS-1:0] c_last_idx   = SEL_BITS'(NUM_REQ - 1);
    localparam logic [SEL_BITS:0]   c_num_req    = (SEL_BITS+1)'(NUM_REQ);

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [SEL_BITS-1:0] r_rr_ptr;
    logic [SEL_BITS-1:0] r_grant_idx;
    logic                r_rq_sop;
    logic                r_rc_in_pkt;
    logic [SEL_BITS-1:0] r_rc_sel;

    logic                w_rst;
    logic                w_pick_valid;
    logic [SEL_BITS-1:0] w_pick_idx;
    logic [SEL_BITS:0]   w_j;
    logic                w_rq_beat;
    logic [SEL_BITS-1:0] w_rc_sel;
    logic                w_rc_hit;
    logic                w_rc_beat;
    logic                w_unused_tready;

    // A dropped link is treated exactly like a reset.
    assign w_rst           = user_reset | ~user_lnk_up;
    assign w_unused_tready = ^s_axis_rq_tready[3:1];

    // Walk from the highest offset down so the nearest valid requester wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_j          = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = {1'b0, r_rr_ptr} + (SEL_BITS+1)'(k);
            if (w_j >= c_num_req) begin
                w_j = w_j - c_num_req;
            end
            if (req_tvalid[w_j[SEL_BITS-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_j[SEL_BITS-1:0];
            end
        end
    end

    assign w_rq_beat = s_axis_rq_tvalid & s_axis_rq_tready[0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE:   if (w_pick_valid) w_state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (w_rq_beat && s_axis_rq_tlast) w_state_nxt = ARB_IDLE;
            default:    w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (w_rst) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_rq_sop    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ARB_IDLE) begin
                r_rq_sop <= 1'b1;
                if (w_pick_valid) begin
                    r_grant_idx <= w_pick_idx;
                end
            end else if (w_rq_beat) begin
                r_rq_sop <= 1'b0;
                if (s_axis_rq_tlast) begin
                    r_rr_ptr <= (r_grant_idx == c_last_idx) ? '0 : r_grant_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_axis_rq_tdata  = '0;
        s_axis_rq_tkeep  = '0;
        s_axis_rq_tuser  = '0;
        s_axis_rq_tlast  = 1'b0;
        s_axis_rq_tvalid = 1'b0;
        req_tready       = '0;
        grant            = '0;
        if (r_state == ARB_LOCKED && !w_rst) begin
            s_axis_rq_tdata  = req_tdata[r_grant_idx*C_DATA_WIDTH +: C_DATA_WIDTH];
            s_axis_rq_tkeep  = req_tkeep[r_grant_idx*KEEP_WIDTH +: KEEP_WIDTH];
            s_axis_rq_tuser  = req_tuser[r_grant_idx*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
            s_axis_rq_tlast  = req_tlast[r_grant_idx];
            s_axis_rq_tvalid = req_tvalid[r_grant_idx];
            req_tready[r_grant_idx] = s_axis_rq_tready[0];
            grant[r_grant_idx]      = 1'b1;
`ifdef RQ_TAG_REMAP_EN
            // Only the descriptor beat carries the tag.
            if (r_rq_sop) begin
                s_axis_rq_tdata[c_rq_tag_msb -: SEL_BITS] = r_grant_idx;
            end
`endif
        end
    end

    // Route is taken from the first beat and held for the whole completion.
    assign w_rc_sel  = r_rc_in_pkt ? r_rc_sel : m_axis_rc_tdata[c_rc_tag_msb -: SEL_BITS];
    assign w_rc_hit  = ({1'b0, w_rc_sel} < c_num_req);
    assign w_rc_beat = m_axis_rc_tvalid & m_axis_rc_tready;

    assign cpl_tdata = m_axis_rc_tdata;
    assign cpl_tuser = m_axis_rc_tuser;
    assign cpl_tkeep = m_axis_rc_tkeep;
    assign cpl_tlast = m_axis_rc_tlast;

    always_comb begin
        cpl_tvalid       = '0;
        m_axis_rc_tready = 1'b0;
        rc_drop          = 1'b0;
        if (!w_rst && m_axis_rc_tvalid) begin
            if (w_rc_hit) begin
                cpl_tvalid[w_rc_sel] = 1'b1;
                m_axis_rc_tready     = cpl_tready[w_rc_sel];
            end else begin
                m_axis_rc_tready = 1'b1;
                rc_drop          = ~r_rc_in_pkt;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (w_rst) begin
            r_rc_in_pkt <= 1'b0;
            r_rc_sel    <= '0;
        end else if (w_rc_beat) begin
            r_rc_in_pkt <= ~m_axis_rc_tlast;
            r_rc_sel    <= w_rc_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcie_rq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_rq_arbiter
// Purpose  : Scoreboard bench for pcie_rq_arbiter (4-port and 3-port copies).
// Revision : 1.0  initial release
// ============================================================================
module tb_pcie_rq_arbiter;

    localparam int N   = 4;
    localparam int DW  = 128;
    localparam int KW  = 4;
    localparam int RQU = 62;
    localparam int RCU = 75;

`ifdef RQ_TAG_REMAP_EN
    localparam logic [7:0] c_tag_r0_exp = 8'h05;
`else
    localparam logic [7:0] c_tag_r0_exp = 8'h45;
`endif

    typedef struct {
        int             idx;
        logic [DW-1:0]  data;
        logic           last;
        logic [RQU-1:0] user;
        int             gap;
    } rq_exp_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          last;
    } rc_exp_t;

    logic user_clk = 1'b0;
    logic user_reset;
    logic user_lnk_up;

    logic [DW-1:0]  d_arr [N];
    logic [RQU-1:0] u_arr [N];
    logic           l_arr [N];
    logic           v_arr [N];

    logic [N*DW-1:0]  req_tdata;
    logic [N*KW-1:0]  req_tkeep;
    logic [N*RQU-1:0] req_tuser;
    logic [N-1:0]     req_tlast, req_tvalid, req_tready;

    logic [DW-1:0]  s_axis_rq_tdata;
    logic [KW-1:0]  s_axis_rq_tkeep;
    logic [RQU-1:0] s_axis_rq_tuser;
    logic           s_axis_rq_tlast, s_axis_rq_tvalid;
    logic [3:0]     s_axis_rq_tready;

    logic [DW-1:0]  rc_tdata;
    logic [RCU-1:0] rc_tuser;
    logic [KW-1:0]  rc_tkeep;
    logic           rc_tlast, rc_tvalid4, rc_tvalid3;
    logic           m_axis_rc_tready;

    logic [DW-1:0]  cpl_tdata;
    logic [RCU-1:0] cpl_tuser;
    logic [KW-1:0]  cpl_tkeep;
    logic           cpl_tlast;
    logic [N-1:0]   cpl_tvalid, cpl_tready;
    logic [N-1:0]   grant;
    logic           rc_drop;

    // Second instance with three requesters exercises unmatched tags.
    logic [3*DW-1:0]  req3_tdata;
    logic [3*KW-1:0]  req3_tkeep;
    logic [3*RQU-1:0] req3_tuser;
    logic [2:0]       req3_tlast, req3_tvalid, req3_tready;
    logic [DW-1:0]    rq3_tdata;
    logic [KW-1:0]    rq3_tkeep;
    logic [RQU-1:0]   rq3_tuser;
    logic             rq3_tlast, rq3_tvalid, rc3_tready;
    logic [DW-1:0]    cpl3_tdata;
    logic [RCU-1:0]   cpl3_tuser;
    logic [KW-1:0]    cpl3_tkeep;
    logic             cpl3_tlast;
    logic [2:0]       cpl3_tvalid, cpl3_tready, grant3;
    logic             rc_drop3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rq_last = 0;
    rq_exp_t rq_q[$];
    rc_exp_t rc_q[$];

    always_comb begin
        req_tdata  = '0;
        req_tuser  = '0;
        req_tlast  = '0;
        req_tvalid = '0;
        for (int i = 0; i < N; i++) begin
            req_tdata[i*DW +: DW]   = d_arr[i];
            req_tuser[i*RQU +: RQU] = u_arr[i];
            req_tlast[i]            = l_arr[i];
            req_tvalid[i]           = v_arr[i];
        end
    end
    assign req_tkeep = '1;

    pcie_rq_arbiter #(.NUM_REQ(4)) u_dut (
        .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
        .req_tdata(req_tdata), .req_tkeep(req_tkeep), .req_tuser(req_tuser),
        .req_tlast(req_tlast), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .s_axis_rq_tdata(s_axis_rq_tdata), .s_axis_rq_tkeep(s_axis_rq_tkeep),
        .s_axis_rq_tuser(s_axis_rq_tuser), .s_axis_rq_tlast(s_axis_rq_tlast),
        .s_axis_rq_tvalid(s_axis_rq_tvalid), .s_axis_rq_tready(s_axis_rq_tready),
        .m_axis_rc_tdata(rc_tdata), .m_axis_rc_tuser(rc_tuser), .m_axis_rc_tkeep(rc_tkeep),
        .m_axis_rc_tlast(rc_tlast), .m_axis_rc_tvalid(rc_tvalid4),
        .m_axis_rc_tready(m_axis_rc_tready),
        .cpl_tdata(cpl_tdata), .cpl_tuser(cpl_tuser), .cpl_tkeep(cpl_tkeep),
        .cpl_tlast(cpl_tlast), .cpl_tvalid(cpl_tvalid), .cpl_tready(cpl_tready),
        .grant(grant), .rc_drop(rc_drop)
    );

    assign req3_tdata  = '0;
    assign req3_tkeep  = '0;
    assign req3_tuser  = '0;
    assign req3_tlast  = '0;
    assign req3_tvalid = '0;
    assign cpl3_tready = '1;

    pcie_rq_arbiter #(.NUM_REQ(3)) u_dut3 (
        .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
        .req_tdata(req3_tdata), .req_tkeep(req3_tkeep), .req_tuser(req3_tuser),
        .req_tlast(req3_tlast), .req_tvalid(req3_tvalid), .req_tready(req3_tready),
        .s_axis_rq_tdata(rq3_tdata), .s_axis_rq_tkeep(rq3_tkeep),
        .s_axis_rq_tuser(rq3_tuser), .s_axis_rq_tlast(rq3_tlast),
        .s_axis_rq_tvalid(rq3_tvalid), .s_axis_rq_tready(4'hF),
        .m_axis_rc_tdata(rc_tdata), .m_axis_rc_tuser(rc_tuser), .m_axis_rc_tkeep(rc_tkeep),
        .m_axis_rc_tlast(rc_tlast), .m_axis_rc_tvalid(rc_tvalid3),
        .m_axis_rc_tready(rc3_tready),
        .cpl_tdata(cpl3_tdata), .cpl_tuser(cpl3_tuser), .cpl_tkeep(cpl3_tkeep),
        .cpl_tlast(cpl3_tlast), .cpl_tvalid(cpl3_tvalid), .cpl_tready(cpl3_tready),
        .grant(grant3), .rc_drop(rc_drop3)
    );

    initial forever #5 user_clk = ~user_clk;
    always @(posedge user_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int r, input int b, input logic [7:0] tag);
        logic [DW-1:0] v;
        v            = '0;
        v[127:120]   = 8'(r);
        v[119:112]   = 8'(b);
        v[103:96]    = tag;
        v[15:0]      = 16'hBEEF;
        return v;
    endfunction

    function automatic logic [DW-1:0] rc_data(input logic [7:0] tag, input int b);
        logic [DW-1:0] v;
        v          = '0;
        v[71:64]   = tag;
        v[127:120] = 8'(b);
        v[31:0]    = 32'hC0DE0000 + 32'(b);
        return v;
    endfunction

    task automatic push_rq(input int r, input int b, input logic [7:0] tag_out,
                           input logic last, input int gap);
        rq_exp_t e;
        e.idx  = r;
        e.data = beat_data(r, b, tag_out);
        e.last = last;
        e.user = RQU'(r * 16 + b);
        e.gap  = gap;
        rq_q.push_back(e);
    endtask

    task automatic push_rc(input int r, input logic [DW-1:0] data, input logic last);
        rc_exp_t e;
        e.idx  = r;
        e.data = data;
        e.last = last;
        rc_q.push_back(e);
    endtask

    task automatic wait_accept(input int r);
        int t;
        t = 0;
        do begin
            @(negedge user_clk);
            t++;
        end while (!req_tready[r] && t < 300);
        if (!req_tready[r]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: requester %0d tready still 0, expected 1", r);
        end
        @(posedge user_clk);
        #1;
    endtask

    task automatic drive_pkt(input int r, input int nb, input logic [7:0] tag);
        for (int b = 0; b < nb; b++) begin
            d_arr[r] = beat_data(r, b, tag);
            u_arr[r] = RQU'(r * 16 + b);
            l_arr[r] = (b == nb - 1);
            v_arr[r] = 1'b1;
            wait_accept(r);
        end
        v_arr[r] = 1'b0;
        l_arr[r] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rq_q.size() != 0 || rc_q.size() != 0) && t < 200) begin
            @(negedge user_clk);
            t++;
        end
        n_tests++;
        if (rq_q.size() != 0 || rc_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d rq / %0d rc entries outstanding, expected 0",
                     rq_q.size(), rc_q.size());
        end
        @(posedge user_clk);
        #1;
    endtask

    always @(negedge user_clk) begin
        rq_exp_t e;
        if (s_axis_rq_tvalid && s_axis_rq_tready[0]) begin
            if (rq_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rq_unexpected: got beat %h, expected no beat", s_axis_rq_tdata);
            end else begin
                e = rq_q.pop_front();
                chk("rq_data", s_axis_rq_tdata, e.data);
                chk("rq_tlast", DW'(s_axis_rq_tlast), DW'(e.last));
                chk("rq_grant", DW'(grant), DW'(4'b0001 << e.idx));
                chk("rq_tuser", DW'(s_axis_rq_tuser), DW'(e.user));
                if (e.gap > 0) chk("rq_gap", DW'(cyc - rq_last), DW'(e.gap));
            end
            rq_last = cyc;
        end
    end

    always @(negedge user_clk) begin
        rc_exp_t e;
        if (|(cpl_tvalid & cpl_tready)) begin
            if (rc_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rc_unexpected: got cpl_tvalid %b, expected none", cpl_tvalid);
            end else begin
                e = rc_q.pop_front();
                chk("rc_route", DW'(cpl_tvalid), DW'(4'b0001 << e.idx));
                chk("rc_data", cpl_tdata, e.data);
                chk("rc_tlast", DW'(cpl_tlast), DW'(e.last));
                chk("rc_ready", DW'(m_axis_rc_tready), DW'(1'b1));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            d_arr[i] = '0;
            u_arr[i] = '0;
            l_arr[i] = 1'b0;
            v_arr[i] = 1'b0;
        end
        user_reset       = 1'b1;
        user_lnk_up      = 1'b1;
        s_axis_rq_tready = 4'hF;
        cpl_tready       = 4'hF;
        rc_tdata         = rc_data(8'h05, 0);
        rc_tuser         = '0;
        rc_tkeep         = '1;
        rc_tlast         = 1'b1;
        rc_tvalid4       = 1'b0;
        rc_tvalid3       = 1'b0;

        // Reset state, with requests pending to show the gating.
        v_arr[0] = 1'b1;
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst_grant", DW'(grant), DW'(4'b0000));
        chk("rst_rq_tvalid", DW'(s_axis_rq_tvalid), DW'(1'b0));
        chk("rst_req_tready", DW'(req_tready), DW'(4'b0000));
        chk("rst_cpl_tvalid", DW'(cpl_tvalid), DW'(4'b0000));
        chk("rst_rc_tready", DW'(m_axis_rc_tready), DW'(1'b0));
        chk("rst_rc_drop", DW'(rc_drop), DW'(1'b0));
        @(posedge user_clk);
        #1;
        user_reset  = 1'b0;
        user_lnk_up = 1'b0;
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        chk("lnk_grant", DW'(grant), DW'(4'b0000));
        chk("lnk_rq_tvalid", DW'(s_axis_rq_tvalid), DW'(1'b0));
        v_arr[0] = 1'b0;
        @(posedge user_clk);
        #1;
        user_lnk_up = 1'b1;
        @(posedge user_clk);
        #1;

        // Fairness: 1-beat packets from everyone, one bubble between grants.
        push_rq(0, 0, 8'h01, 1'b1, 0);
        push_rq(1, 0, 8'h42, 1'b1, 2);
        push_rq(2, 0, 8'h83, 1'b1, 2);
        push_rq(3, 0, 8'hC4, 1'b1, 2);
        push_rq(0, 0, 8'h01, 1'b1, 2);
        push_rq(1, 0, 8'h42, 1'b1, 2);
        fork
            begin drive_pkt(0, 1, 8'h01); drive_pkt(0, 1, 8'h01); end
            begin drive_pkt(1, 1, 8'h42); drive_pkt(1, 1, 8'h42); end
            drive_pkt(2, 1, 8'h83);
            drive_pkt(3, 1, 8'hC4);
        join
        drain();

        // Single requester 2-beat packet, then requester 0 with a foreign tag.
        push_rq(1, 0, 8'h45, 1'b0, 0);
        push_rq(1, 1, 8'h45, 1'b1, 1);
        drive_pkt(1, 2, 8'h45);
        drain();
        push_rq(0, 0, c_tag_r0_exp, 1'b1, 0);
        drive_pkt(0, 1, 8'h45);
        drain();

        // Backpressure on a 3-beat packet from requester 2; requester 0 joins mid-packet.
        push_rq(2, 0, 8'h80, 1'b0, 0);
        push_rq(2, 1, 8'h80, 1'b0, 3);
        push_rq(2, 2, 8'h80, 1'b1, 1);
        push_rq(0, 0, 8'h02, 1'b1, 2);
        fork
            drive_pkt(2, 3, 8'h80);
            begin
                repeat (3) @(posedge user_clk);
                #1;
                drive_pkt(0, 1, 8'h02);
            end
            begin
                int t;
                t = 0;
                do begin
                    @(negedge user_clk);
                    t++;
                end while (!grant[2] && t < 50);
                chk("bp_grant_seen", DW'(grant[2]), DW'(1'b1));
                @(posedge user_clk);
                #1;
                s_axis_rq_tready = 4'h0;
                @(posedge user_clk);
                @(negedge user_clk);
                chk("bp_hold_grant", DW'(grant), DW'(4'b0100));
                chk("bp_r0_blocked", DW'(req_tready[0]), DW'(1'b0));
                @(posedge user_clk);
                #1;
                s_axis_rq_tready = 4'hF;
            end
        join
        drain();

        // RC steering: tag 0x83 goes to requester 2, stall, then second beat with other MSBs.
        rc_tdata   = rc_data(8'h83, 0);
        rc_tlast   = 1'b0;
        rc_tvalid4 = 1'b1;
        cpl_tready = 4'b1011;
        @(negedge user_clk);
        chk("rc_stall_route", DW'(cpl_tvalid), DW'(4'b0100));
        chk("rc_stall_ready", DW'(m_axis_rc_tready), DW'(1'b0));
        @(posedge user_clk);
        #1;
        push_rc(2, rc_data(8'h83, 0), 1'b0);
        cpl_tready = 4'hF;
        @(posedge user_clk);
        #1;
        push_rc(2, rc_data(8'h05, 1), 1'b1);
        rc_tdata = rc_data(8'h05, 1);
        rc_tlast = 1'b1;
        @(posedge user_clk);
        #1;
        push_rc(0, rc_data(8'h05, 2), 1'b1);
        rc_tdata = rc_data(8'h05, 2);
        @(posedge user_clk);
        #1;
        rc_tvalid4 = 1'b0;
        drain();

        // Unmatched tag on the 3-requester copy.
        rc_tdata   = rc_data(8'hC1, 0);
        rc_tlast   = 1'b0;
        rc_tvalid3 = 1'b1;
        @(negedge user_clk);
        chk("drop_pulse", DW'(rc_drop3), DW'(1'b1));
        chk("drop_ready", DW'(rc3_tready), DW'(1'b1));
        chk("drop_cpl_tvalid", DW'(cpl3_tvalid), DW'(3'b000));
        @(posedge user_clk);
        #1;
        rc_tdata = rc_data(8'h41, 1);
        rc_tlast = 1'b1;
        @(negedge user_clk);
        chk("drop_second_pulse", DW'(rc_drop3), DW'(1'b0));
        chk("drop_second_cpl", DW'(cpl3_tvalid), DW'(3'b000));
        @(posedge user_clk);
        #1;
        rc_tvalid3 = 1'b0;

        // Reset while beat 2 of a 3-beat packet is on the bus.
        push_rq(1, 0, 8'h41, 1'b0, 0);
        d_arr[1] = beat_data(1, 0, 8'h41);
        u_arr[1] = RQU'(16);
        l_arr[1] = 1'b0;
        v_arr[1] = 1'b1;
        wait_accept(1);
        s_axis_rq_tready = 4'h0;
        d_arr[1] = beat_data(1, 1, 8'h41);
        u_arr[1] = RQU'(17);
        @(negedge user_clk);
        chk("mid_beat2_valid", DW'(s_axis_rq_tvalid), DW'(1'b1));
        #1;
        user_reset       = 1'b1;
        s_axis_rq_tready = 4'hF;
        @(posedge user_clk);
        #1;
        v_arr[1] = 1'b0;
        @(negedge user_clk);
        chk("mid_rst_grant", DW'(grant), DW'(4'b0000));
        chk("mid_rst_tvalid", DW'(s_axis_rq_tvalid), DW'(1'b0));
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        chk("post_rst_idle", DW'(grant), DW'(4'b0000));
        @(posedge user_clk);
        #1;
        push_rq(3, 0, 8'hC0, 1'b1, 0);
        drive_pkt(3, 1, 8'hC0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_rq_arbiter.md
Name: pcie_rq_arbiter

Overview:
- Shares the single PCIe requester-request (RQ) AXIS port among NUM_REQ internal requesters: configurator, NVMe SQ doorbell/command engine, and data mover.
- Arbitration is round-robin and packet-granular. Requester-completion (RC) beats are steered back to the requester that issued the request, using the upper tag bits.
- Sits between the requester blocks and the PCIe core RQ/RC interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- C_DATA_WIDTH, 128, AXIS data width.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width.
- AXI4_RQ_TUSER_WIDTH, 62, RQ tuser width.
- AXI4_RC_TUSER_WIDTH, 75, RC tuser width.
- SEL_BITS, 2, tag MSBs used as requester index.

Ports:
- user_clk  in  1  clock
- user_reset  in  1  synchronous active-high reset
- user_lnk_up  in  1  link up; low acts as reset
- req_tdata  in  NUM_REQ*C_DATA_WIDTH  requester RQ data; slice i = requester i
- req_tkeep  in  NUM_REQ*KEEP_WIDTH  requester tkeep
- req_tuser  in  NUM_REQ*AXI4_RQ_TUSER_WIDTH  requester tuser
- req_tlast  in  NUM_REQ  requester tlast
- req_tvalid  in  NUM_REQ  requester tvalid
- req_tready  out  NUM_REQ  requester tready
- s_axis_rq_tdata/tkeep/tuser/tlast/tvalid  out  C_DATA_WIDTH/KEEP_WIDTH/AXI4_RQ_TUSER_WIDTH/1/1  to core
- s_axis_rq_tready  in  4  core ready; bit 0 used
- m_axis_rc_tdata/tuser/tkeep/tlast/tvalid  in  as widths above  from core
- m_axis_rc_tready  out  1  RC ready to core
- cpl_tdata/tuser/tkeep/tlast  out  shared widths  RC beat broadcast to all requesters
- cpl_tvalid  out  NUM_REQ  per-requester RC valid
- cpl_tready  in  NUM_REQ  per-requester RC ready
- grant  out  NUM_REQ  one-hot current owner (debug)
- rc_drop  out  1  pulse: RC beat discarded

Behaviour:
- Reset (user_reset or !user_lnk_up):
  - State ARB_IDLE; rr pointer 0; grant 0; req_tready 0.
  - s_axis_rq_tvalid 0; cpl_tvalid 0; rc_drop 0.
  - RC route register cleared; rc_in_pkt 0.
  - Reset mid-packet abandons the packet; no tlast is synthesised.
- RQ FSM, ARB_IDLE:
  - If any req_tvalid: grant the first valid requester searching from rr pointer upward, with wrap.
  - Go to ARB_LOCKED. This costs one bubble cycle; no beat passes in ARB_IDLE.
- RQ FSM, ARB_LOCKED:
  - Combinational pass-through: s_axis_rq_* = req_*[g]; req_tready[g] = s_axis_rq_tready[0]; all other req_tready 0.
  - On a beat with tvalid&tready&tlast: rr pointer = g+1 mod NUM_REQ; return to ARB_IDLE.
  - Grant never changes mid-packet, regardless of other requests.
- First-beat tracking: rq_sop is set in ARB_IDLE and cleared after the first accepted beat. The descriptor is on the first beat only.
- RC routing:
  - On the first RC beat (rc_in_pkt=0), sel = m_axis_rc_tdata[71:70] (tag MSBs). Latch sel; set rc_in_pkt.
  - Route held until the tlast beat is accepted.
  - sel < NUM_REQ: cpl_tvalid[sel] = m_axis_rc_tvalid; m_axis_rc_tready = cpl_tready[sel].
  - sel >= NUM_REQ: m_axis_rc_tready = 1; beats discarded; rc_drop pulses once, on the first beat.
  - Zero-latency combinational steering for both routing cases.
- Simultaneous events: RC and RQ paths are independent; both may transfer in the same cycle.
- All requesters valid: service order 0,1,2,3,0,… with one bubble between packets.

Optional Feature:
- RQ_TAG_REMAP_EN defined: on the rq_sop beat, s_axis_rq_tdata[103:102] is overwritten with the grant index g; all other bits pass unchanged. Requesters use tags 0..63 only.
- RQ_TAG_REMAP_EN undefined: tdata passes unmodified. Each requester must issue tags whose bits [7:6] equal its own index. RC routing is identical in both builds.

Test Plan:
- Reset values: hold user_reset 3 cycles, then user_lnk_up=0 → grant=0, s_axis_rq_tvalid=0, cpl_tvalid=0, m_axis_rc_tready=0 while no RC traffic.
- Single requester: requester 1 sends a 2-beat MemWr (tag 0x45) with tready=1 → beats appear on s_axis_rq one cycle after grant, in order. With RQ_TAG_REMAP_EN, tdata[103:96]=0x45 becomes 0x45 with bits[7:6]=01 (=0x45); requester 0 tag 0x45 → 0x05.
- Fairness: all 4 requesters stream 1-beat packets continuously → grant order 0,1,2,3,0,1; each packet separated by exactly one idle cycle.
- Hold grant under backpressure: requester 2 sends a 3-beat packet; s_axis_rq_tready toggles 1,0,0,1,1; requester 0 asserts mid-packet → all 3 beats go out before grant moves to requester 3 or 0 (rr order); no interleaving.
- RC steering: 2-beat completion, tag 0x83 → cpl_tvalid[2] only; cpl_tready[2]=0 stalls m_axis_rc_tready. Second beat still routes to 2, even if its tdata[71:70] differ.
- Unmatched completion and reset mid-packet: with NUM_REQ=3, tag 0xC1 → beats sunk, rc_drop=1 for 1 cycle. Assert user_reset during beat 2 of a 3-beat RQ packet → next cycle state ARB_IDLE and s_axis_rq_tvalid=0.
